// File: rtl/fib_stream_checker.sv
// Stream checker: compares accepted words against an internal Fibonacci sequence.
// Optional FIB_CHK_RESYNC_EN: restart the sequence on a mismatch and count all mismatches.
module fib_stream_checker #(
  parameter int W  = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          busy,
  output logic          match,
  output logic          err,
  output logic [CW-1:0] err_index,
  output logic [W-1:0]  err_expected,
  output logic [CW-1:0] count,
`ifdef FIB_CHK_RESYNC_EN
  output logic [CW-1:0] err_count,
`endif
  output logic          done
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // CHECK | accepting words and comparing against exp_q
  // DONE  | last representable term checked OK
  // FAIL  | mismatch seen, holding results until start
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state_q;
  logic [W-1:0]  exp_q, nxt_q;
  logic          ovf_q;
  logic          match_q, err_q, done_q;
  logic [CW-1:0] err_index_q, count_q;
  logic [W-1:0]  err_expected_q;
  logic [W:0]    nxt_d;
  logic [CW-1:0] count_d;
  logic          xfer;

  // ovf_q marks that nxt_q wrapped; the term in exp_q is then the last one representable
  assign nxt_d   = {1'b0, exp_q} + {1'b0, nxt_q};
  assign count_d = (count_q == CNT_MAX) ? count_q : count_q + CW'(1);
  assign xfer    = (state_q == ST_CHECK) && in_valid;

`ifdef FIB_CHK_RESYNC_EN
  logic [CW-1:0] err_count_q;
  assign err_count = err_count_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      exp_q          <= '0;
      nxt_q          <= W'(1);
      ovf_q          <= 1'b0;
      match_q        <= 1'b0;
      err_q          <= 1'b0;
      done_q         <= 1'b0;
      err_index_q    <= '0;
      err_expected_q <= '0;
      count_q        <= '0;
`ifdef FIB_CHK_RESYNC_EN
      err_count_q    <= '0;
`endif
    end else begin
      match_q <= 1'b0;
      if (start) begin
        state_q        <= ST_CHECK;
        exp_q          <= '0;
        nxt_q          <= W'(1);
        ovf_q          <= 1'b0;
        err_q          <= 1'b0;
        done_q         <= 1'b0;
        err_index_q    <= '0;
        err_expected_q <= '0;
        count_q        <= '0;
`ifdef FIB_CHK_RESYNC_EN
        err_count_q    <= '0;
`endif
      end else if (xfer) begin
        count_q <= count_d;
        if (in_data == exp_q) begin
          match_q <= 1'b1;
          if (ovf_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            exp_q <= nxt_q;
            nxt_q <= nxt_d[W-1:0];
            ovf_q <= nxt_d[W];
          end
        end else begin
`ifdef FIB_CHK_RESYNC_EN
          if (!err_q) begin
            err_q          <= 1'b1;
            err_index_q    <= count_q;
            err_expected_q <= exp_q;
          end
          if (err_count_q != CNT_MAX) err_count_q <= err_count_q + CW'(1);
          exp_q <= '0;
          nxt_q <= W'(1);
          ovf_q <= 1'b0;
`else
          err_q          <= 1'b1;
          err_index_q    <= count_q;
          err_expected_q <= exp_q;
          state_q        <= ST_FAIL;
`endif
        end
      end
    end
  end

  assign in_ready     = (state_q == ST_CHECK);
  assign busy         = (state_q == ST_CHECK);
  assign match        = match_q;
  assign err          = err_q;
  assign err_index    = err_index_q;
  assign err_expected = err_expected_q;
  assign count        = count_q;
  assign done         = done_q;

endmodule

// File: tb/tb_fib_stream_checker.sv
// Scoreboard bench for fib_stream_checker at W=8: driver queues the expected match
// bit per accepted word, a monitor compares the registered match pulse each cycle.
module tb_fib_stream_checker;
  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready, busy, match, err, done;
  logic [CW-1:0] err_index, count;
  logic [W-1:0]  err_expected;
`ifdef FIB_CHK_RESYNC_EN
  logic [CW-1:0] err_count;
`endif

  fib_stream_checker #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .match(match), .err(err),
    .err_index(err_index), .err_expected(err_expected), .count(count),
`ifdef FIB_CHK_RESYNC_EN
    .err_count(err_count),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit exp_match_q[$];
  bit pend = 1'b0;

  logic [W-1:0] fib [14] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                             8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: match must follow exactly the transfers seen in the previous cycle
  initial begin
    bit m;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_match_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          m = exp_match_q.pop_front();
          chk("match_pulse", {31'd0, match}, {31'd0, m});
        end
      end else begin
        chk("match_idle", {31'd0, match}, 32'd0);
      end
      pend = in_valid && in_ready && !start && rst;
    end
  end

  // Inputs change at posedge+1; each task returns at posedge+1
  task automatic send(input logic [W-1:0] d, input bit m);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_match_q.push_back(m);
        break;
      end
      if (++n > 20) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input bit v, input logic [W-1:0] d);
    start    = 1'b1;
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    if (v) chk("start_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic chk_done_state(input string tag);
    chk({tag, "_count"}, {24'd0, count}, 32'd14);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {24'd0, count}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    idle(2);
    chk("idle_ready", {31'd0, in_ready}, 32'd0);

    // full sequence, valid held high
    pulse_start(1'b0, '0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 14; i++) send(fib[i], 1'b1);
    chk_done_state("s1");
    idle(3);
    chk("s1_hold_done", {31'd0, done}, 32'd1);

`ifndef FIB_CHK_RESYNC_EN
    // mismatch on the fifth word
    pulse_start(1'b0, '0);
    send(8'd0, 1'b1); send(8'd1, 1'b1); send(8'd1, 1'b1); send(8'd2, 1'b1);
    send(8'd4, 1'b0);
    chk("s2_err", {31'd0, err}, 32'd1);
    chk("s2_err_index", {24'd0, err_index}, 32'd4);
    chk("s2_err_expected", {24'd0, err_expected}, 32'd3);
    chk("s2_count", {24'd0, count}, 32'd5);
    chk("s2_ready", {31'd0, in_ready}, 32'd0);
    idle(2);
    chk("s2_hold_err", {31'd0, err}, 32'd1);
    pulse_start(1'b0, '0);
    chk("s2_restart_err", {31'd0, err}, 32'd0);
    chk("s2_restart_count", {24'd0, count}, 32'd0);
    chk("s2_restart_ready", {31'd0, in_ready}, 32'd1);
`endif

    // same sequence with random gaps in valid
    pulse_start(1'b0, '0);
    for (int i = 0; i < 14; i++) begin
      idle($urandom_range(0, 2));
      send(fib[i], 1'b1);
    end
    chk_done_state("s3");

    // start outranks a same-cycle word
    pulse_start(1'b0, '0);
    pulse_start(1'b1, 8'd7);
    chk("s5_count", {24'd0, count}, 32'd0);
    send(8'd0, 1'b1);
    chk("s5_count1", {24'd0, count}, 32'd1);

    // reset after the fifth word
    send(8'd1, 1'b1); send(8'd1, 1'b1); send(8'd2, 1'b1); send(8'd3, 1'b1);
    chk("s4_count5", {24'd0, count}, 32'd5);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("s4_count", {24'd0, count}, 32'd0);
    chk("s4_ready", {31'd0, in_ready}, 32'd0);
    chk("s4_busy", {31'd0, busy}, 32'd0);
    chk("s4_err", {31'd0, err}, 32'd0);
    chk("s4_done", {31'd0, done}, 32'd0);
    chk("s4_err_index", {24'd0, err_index}, 32'd0);
    chk("s4_err_expected", {24'd0, err_expected}, 32'd0);
    idle(3);
    chk("s4_ready_later", {31'd0, in_ready}, 32'd0);

`ifdef FIB_CHK_RESYNC_EN
    // mismatch restarts the sequence
    pulse_start(1'b0, '0);
    send(8'd0, 1'b1); send(8'd1, 1'b1); send(8'd9, 1'b0);
    send(8'd0, 1'b1); send(8'd1, 1'b1); send(8'd1, 1'b1);
    chk("s6_err", {31'd0, err}, 32'd1);
    chk("s6_err_index", {24'd0, err_index}, 32'd2);
    chk("s6_err_expected", {24'd0, err_expected}, 32'd1);
    chk("s6_err_count", {24'd0, err_count}, 32'd1);
    chk("s6_count", {24'd0, count}, 32'd6);
    chk("s6_busy", {31'd0, busy}, 32'd1);
`endif

    idle(3);
    chk("sb_empty", exp_match_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
